// File: rtl/wb_master_seq_if.sv
// Wishbone classic bus bundle between the traffic engine and a slave.
interface wb_master_seq_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              CYC_O;
    logic              STB_O;
    logic              WE_O;
    logic [ADDR_W-1:0] ADR_O;
    logic [DATA_W-1:0] DAT_O;
    logic [DATA_W-1:0] DAT_I;
    logic              ACK_I;
    logic              ERR_I;

    modport master (
        output CYC_O, STB_O, WE_O, ADR_O, DAT_O,
        input  DAT_I, ACK_I, ERR_I
    );

    modport slave (
        input  CYC_O, STB_O, WE_O, ADR_O, DAT_O,
        output DAT_I, ACK_I, ERR_I
    );
endinterface

// File: rtl/wb_master_seq.sv
// Wishbone classic traffic engine: queued commands, programmable idle gap,
// one CYC/STB access per command, one response pulse per command.
module wb_master_seq #(
    parameter int          ADDR_W     = 32,
    parameter int          DATA_W     = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter int          GAP_MIN    = 4,
    parameter int          GAP_RND_W  = 4,
    parameter int          TIMEOUT    = 64,
    parameter int          POST_IDLE  = 5,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              rnd_en_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_adr_i,
    input  logic [DATA_W-1:0] cmd_dat_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_dat_o,
    output logic              rsp_err_o,
    output logic              rsp_tmo_o,
    output logic              busy_o,
    output logic [15:0]       txn_cnt_o,
    wb_master_seq_if.master   wb
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int GAP_MAX = GAP_MIN + (1 << GAP_RND_W) - 1;
    localparam int GAP_W   = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;
    localparam int TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int HOLD_W  = (POST_IDLE > 0) ? $clog2(POST_IDLE + 1) : 1;

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] adr;
        logic [DATA_W-1:0] dat;
    } cmd_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GAP,
        S_BUS,
        S_RSP,
        S_HOLD
    } state_t;

    state_t state, state_n;

    cmd_t             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_cnt;
    logic             fifo_avail;
    logic             push, pop;

    cmd_t              cur;
    logic [15:0]       lfsr;
    logic [GAP_W-1:0]  gap_cnt, gap_load;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              tmo_hit, bus_end, bus_act;

    assign cmd_ready_o = !RST_I && (fifo_cnt != FULL_CNT);
    assign push        = cmd_valid_i && cmd_ready_o;
    assign busy_o      = (state != S_IDLE) || (fifo_cnt != '0);

    assign gap_load = GAP_W'(GAP_MIN) + (rnd_en_i ? GAP_W'(lfsr[GAP_RND_W-1:0]) : '0);
    assign tmo_hit  = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

    // Bus strobes are a pure decode of the state so they drop on the same edge that ends the access.
    assign bus_act   = (state == S_BUS);
    assign wb.CYC_O  = bus_act;
    assign wb.STB_O  = bus_act;
    assign wb.WE_O   = bus_act && cur.we;
    assign wb.ADR_O  = bus_act ? cur.adr : '0;
    assign wb.DAT_O  = (bus_act && cur.we) ? cur.dat : '0;

    // Command storage; memory itself needs no reset, pointers do.
    always_ff @(posedge CLK_I) begin
        if (push) fifo_mem[wr_ptr] <= '{we: cmd_we_i, adr: cmd_adr_i, dat: cmd_dat_i};
    end

    // FIFO pointers and occupancy. The engine sees occupancy one cycle late,
    // which keeps the FIFO count off the FSM decode path.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            fifo_avail <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            fifo_avail <= (fifo_cnt != '0);
        end
    end

    // Free-running gap LFSR, x^16 + x^14 + x^13 + x^11 + 1.
    always_ff @(posedge CLK_I) begin
        if (RST_I) lfsr <= LFSR_SEED;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // State register.
    always_ff @(posedge CLK_I) begin
        if (RST_I) state <= S_IDLE;
        else       state <= state_n;
    end

    // Next-state decode; the access terminates on ACK, ERR or timeout.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        bus_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (fifo_avail) begin
                    pop     = 1'b1;
                    state_n = (gap_load == '0) ? S_BUS : S_GAP;
                end
            end
            S_GAP:  if (gap_cnt <= GAP_W'(1)) state_n = S_BUS;
            S_BUS: begin
                if (wb.ACK_I || wb.ERR_I || tmo_hit) begin
                    bus_end = 1'b1;
                    state_n = S_RSP;
                end
            end
            S_RSP:  state_n = (POST_IDLE == 0) ? S_IDLE : S_HOLD;
            S_HOLD: if (hold_cnt <= HOLD_W'(1)) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Holding register and the gap / timeout / post-idle counters.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            cur      <= '0;
            gap_cnt  <= '0;
            tmo_cnt  <= '0;
            hold_cnt <= '0;
        end else begin
            if (pop) begin
                cur     <= fifo_mem[rd_ptr];
                gap_cnt <= gap_load;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
            tmo_cnt <= bus_act ? tmo_cnt + TMO_W'(1) : '0;
            if (state == S_RSP)       hold_cnt <= HOLD_W'(POST_IDLE);
            else if (state == S_HOLD) hold_cnt <= hold_cnt - HOLD_W'(1);
        end
    end

    // Response pulse and transaction count, registered on the terminating edge.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            rsp_valid_o <= 1'b0;
            rsp_dat_o   <= '0;
            rsp_err_o   <= 1'b0;
            rsp_tmo_o   <= 1'b0;
            txn_cnt_o   <= '0;
        end else begin
            rsp_valid_o <= bus_end;
            rsp_dat_o   <= (bus_end && wb.ACK_I && !wb.ERR_I && !cur.we) ? wb.DAT_I : '0;
            rsp_err_o   <= bus_end && (wb.ERR_I || !wb.ACK_I);
            rsp_tmo_o   <= bus_end && !wb.ERR_I && !wb.ACK_I;
            if (bus_end) txn_cnt_o <= txn_cnt_o + 16'd1;
        end
    end
endmodule

// File: tb/tb_wb_master_seq.sv
// Randomized bench for wb_master_seq: scoreboard of issued commands plus a
// Wishbone slave whose behaviour is chosen per command.
module tb_wb_master_seq;
    localparam int ADDR_W = 32, DATA_W = 32, FIFO_DEPTH = 4, GAP_MIN = 4;
    localparam int GAP_RND_W = 4, TIMEOUT = 64, POST_IDLE = 5;

    // mode: 0 ACK, 1 ERR, 2 ACK+ERR, 3 silent (timeout)
    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          mode;
        int          dly;
        int          acc;
        bit          rnd;
    } tcmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rnd_en = 1'b0;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic        cmd_ready, rsp_valid, rsp_err, rsp_tmo, busy;
    logic [31:0] rsp_dat;
    logic [15:0] txn_cnt;

    wb_master_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    wb_master_seq #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .GAP_MIN(GAP_MIN),
        .GAP_RND_W(GAP_RND_W), .TIMEOUT(TIMEOUT), .POST_IDLE(POST_IDLE), .LFSR_SEED(16'hACE1)
    ) dut (
        .CLK_I(clk), .RST_I(rst), .rnd_en_i(rnd_en),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err), .rsp_tmo_o(rsp_tmo),
        .busy_o(busy), .txn_cnt_o(txn_cnt), .wb(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int    checks = 0, errors = 0;
    tcmd_t issue_q[$];
    tcmd_t cur;
    bit    have_cur = 0, stb_prev = 0, noise = 0;
    int    stb_len = 0, last_fall = -1000, n_done = 0;
    bit    seen [0:63];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : ((a ^ 32'h5A5AA5A5) + 32'h1234);
    endfunction

    // Monitor + slave: checks each access against the scoreboard, then drives the slave reply.
    initial begin
        bus.ACK_I = 0; bus.ERR_I = 0; bus.DAT_I = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                issue_q.delete();
                have_cur = 0; stb_prev = 0; stb_len = 0;
                last_fall = -1000; n_done = 0;
                bus.ACK_I = 0; bus.ERR_I = 0;
                continue;
            end
            if (bus.STB_O && !stb_prev) begin
                stb_len = 0;
                if (issue_q.size() == 0) begin
                    chk("stb_unexpected", 1, 0);
                end else begin
                    int base, g;
                    cur = issue_q.pop_front();
                    have_cur = 1;
                    base = (cur.acc + 2 > last_fall + 2 + POST_IDLE) ? cur.acc + 2 : last_fall + 2 + POST_IDLE;
                    g = cyc - base;
                    if (!cur.rnd) chk("gap", g, GAP_MIN);
                    else begin
                        chk("gap_range", (g >= GAP_MIN) && (g <= GAP_MIN + 15), 1);
                        if (g >= 0 && g < 64) seen[g] = 1;
                    end
                end
            end
            if (bus.STB_O && have_cur) begin
                stb_len++;
                chk("cyc_o", bus.CYC_O, 1);
                chk("we_o", bus.WE_O, cur.we);
                chk("adr_o", bus.ADR_O, cur.adr);
                chk("dat_o", bus.DAT_O, cur.we ? cur.dat : 32'h0);
            end
            if (!bus.STB_O && stb_prev && have_cur) begin
                logic [31:0] edat;
                last_fall = cyc;
                have_cur = 0;
                n_done++;
                edat = (cur.mode == 0 && !cur.we) ? rd_fn(cur.adr) : 32'h0;
                chk("stb_len", stb_len, (cur.mode == 3) ? TIMEOUT : cur.dly + 1);
                chk("rsp_valid", rsp_valid, 1);
                chk("rsp_dat", rsp_dat, edat);
                chk("rsp_err", rsp_err, cur.mode != 0);
                chk("rsp_tmo", rsp_tmo, cur.mode == 3);
                chk("bus_idle", {bus.CYC_O, bus.WE_O, bus.ADR_O, bus.DAT_O}, 0);
            end else if (rsp_valid) begin
                chk("rsp_spurious", 1, 0);
            end
            stb_prev = bus.STB_O;
            if (bus.STB_O && have_cur) begin
                bit fire;
                fire = (cur.mode != 3) && (stb_len > cur.dly);
                bus.ACK_I = fire && (cur.mode == 0 || cur.mode == 2);
                bus.ERR_I = fire && (cur.mode == 1 || cur.mode == 2);
                bus.DAT_I = rd_fn(bus.ADR_O);
            end else begin
                bus.ACK_I = noise && $urandom_range(0, 1);
                bus.ERR_I = noise && $urandom_range(0, 1);
                bus.DAT_I = $urandom;
            end
        end
    end

    task automatic send(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input int mode, input int dly);
        tcmd_t c;
        int t = 0;
        @(negedge clk);
        cmd_valid = 1; cmd_we = we; cmd_adr = adr; cmd_dat = dat;
        while (!cmd_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 0;
            return;
        end
        c.we = we; c.adr = adr; c.dat = dat; c.mode = mode; c.dly = dly;
        c.acc = cyc + 1; c.rnd = rnd_en;
        issue_q.push_back(c);
        @(posedge clk);
        #1 cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || have_cur || issue_q.size() != 0) && t < 3000);
        chk("idle_reached", t < 3000, 1);
        chk("txn_cnt", txn_cnt, 16'(n_done));
    endtask

    task automatic wait_stb();
        int t = 0;
        while (!bus.STB_O && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("stb_seen", bus.STB_O, 1);
    endtask

    initial begin
        int ndist;
        for (int i = 0; i < 64; i++) seen[i] = 0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_cyc", bus.CYC_O, 0);
        chk("rst_busy", busy, 0);
        chk("rst_txn", txn_cnt, 0);
        chk("rst_rsp", rsp_valid, 0);
        #2 rst = 0;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);

        // directed: write, read, timeout, ACK+ERR
        send(1, 32'h0, 32'h00030201, 0, 3);
        wait_idle();
        send(0, 32'h10, 32'h0, 0, 1);
        wait_idle();
        send(0, 32'h20, 32'h0, 3, 0);
        wait_idle();
        send(1, 32'h30, 32'h11223344, 2, 2);
        wait_idle();

        // FIFO full: one access in flight, then five pushed back-to-back
        send(0, 32'h100, 32'h0, 0, 7);
        @(negedge clk);
        wait_stb();
        for (int i = 0; i < 4; i++) send(i[0], 32'h200 + 32'(i * 4), 32'hA000 + 32'(i), 0, i);
        @(negedge clk);
        chk("full_ready", cmd_ready, 0);
        chk("full_busy", busy, 1);
        send(1, 32'h210, 32'hA004, 1, 0);
        wait_idle();

        // random mix, fixed gap, noisy ACK/ERR outside the access
        noise = 1;
        for (int i = 0; i < 60; i++) begin
            int r, m;
            r = $urandom_range(0, 7);
            m = (r < 5) ? 0 : r - 4;
            send($urandom_range(0, 1), $urandom, $urandom, m, $urandom_range(0, 5));
        end
        wait_idle();

        // random gaps, FIFO kept fed
        rnd_en = 1;
        for (int i = 0; i < 1000; i++) send(1, $urandom, $urandom, 0, $urandom_range(0, 3));
        wait_idle();
        rnd_en = 0;
        ndist = 0;
        for (int i = 0; i < 64; i++) if (seen[i]) ndist++;
        chk("gap_distinct_ge8", ndist >= 8, 1);

        // reset in the middle of an access
        send(0, 32'h40, 32'h0, 3, 0);
        @(negedge clk);
        wait_stb();
        repeat (10) @(negedge clk);
        #2 rst = 1;
        @(negedge clk);
        chk("midrst_cyc", bus.CYC_O, 0);
        chk("midrst_stb", bus.STB_O, 0);
        chk("midrst_rsp", rsp_valid, 0);
        chk("midrst_txn", txn_cnt, 0);
        chk("midrst_ready", cmd_ready, 0);
        #2 rst = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("post_rst_rsp", rsp_valid, 0);
            chk("post_rst_cyc", bus.CYC_O, 0);
        end
        chk("post_rst_txn", txn_cnt, 0);

        // recovery
        send(0, 32'h10, 32'h0, 0, 2);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        chk("global_timeout", 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_master_seq.md
Name: wb_master_seq

Overview:
- Synthesizable, parametrised Wishbone classic master that replaces bench-only write sequencing with a reusable traffic engine.
- Accepts queued read/write commands, inserts a programmable (optionally pseudo-random) idle gap before each access, and runs one CYC/STB cycle per command.
- Waits for ACK_I or ERR_I, or a timeout, then returns one response per command.
- Sits between a test controller/CPU-side command source and any Wishbone slave in the design.

Parameters:
- ADDR_W, 32, Wishbone address width.
- DATA_W, 32, Wishbone data width.
- FIFO_DEPTH, 4, command FIFO entries; power of two, >=2.
- GAP_MIN, 4, minimum idle cycles before each access.
- GAP_RND_W, 4, width of random gap addend: gap = GAP_MIN + (lfsr[GAP_RND_W-1:0]).
- TIMEOUT, 64, max cycles STB_O held without ACK_I/ERR_I; 0 disables timeout.
- POST_IDLE, 5, cycles CYC_O held low after each access before next gap starts.
- LFSR_SEED, 16'hACE1, reset value of 16-bit Fibonacci LFSR (taps 16,14,13,11); must be nonzero.

Ports:
- CLK_I  in  1  system clock
- RST_I  in  1  synchronous active-high reset
- rnd_en_i  in  1  1: random gap; 0: gap = GAP_MIN exactly
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  FIFO not full
- cmd_we_i  in  1  1 write, 0 read
- cmd_adr_i  in  ADDR_W  command address
- cmd_dat_i  in  DATA_W  write data
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_dat_o  out  DATA_W  read data (0 for writes/errors)
- rsp_err_o  out  1  ERR_I seen or timeout
- rsp_tmo_o  out  1  timeout cause
- busy_o  out  1  FSM not IDLE or FIFO not empty
- txn_cnt_o  out  16  completed transactions, wraps at 16'hFFFF->0
- CYC_O, STB_O, WE_O  out  1 each  Wishbone strobes
- ADR_O  out  ADDR_W  Wishbone address
- DAT_O  out  DATA_W  Wishbone write data
- DAT_I  in  DATA_W  Wishbone read data
- ACK_I, ERR_I  in  1 each  slave termination

Behaviour:
- Reset (RST_I=1 at CLK_I edge): FSM=IDLE, FIFO emptied, LFSR=LFSR_SEED; CYC_O/STB_O/WE_O=0, ADR_O/DAT_O=0, rsp_*=0, txn_cnt_o=0, busy_o=0, cmd_ready_o=0 during reset, 1 the first cycle after. Reset mid-access drops CYC_O/STB_O on the next edge; no response issued.
- FIFO: push on cmd_valid_i&cmd_ready_o; cmd_ready_o=0 when FIFO_DEPTH entries are held. Simultaneous push and pop when full is not accepted (ready is already low). Simultaneous push and pop otherwise keeps the count.
- LFSR advances every cycle, outside reset.
- IDLE: on FIFO non-empty, pop head into a holding register and load the gap counter with GAP_MIN + (rnd_en_i ? lfsr[GAP_RND_W-1:0] : 0), sampled that cycle. Go to GAP; with a gap of 0, go directly to BUS.
- GAP: decrement each cycle; at 1, go to BUS.
- BUS: CYC_O=STB_O=1; WE_O/ADR_O/DAT_O from the holding register, stable for the whole state. The timeout counter starts at 0 and increments each cycle.
  - ACK_I=1: capture DAT_I if it is a read, then go to RSP.
  - ERR_I=1, or ACK_I&ERR_I together: err=1, dat=0, go to RSP (ERR wins).
  - Counter reaches TIMEOUT-1 with no termination: err=1, tmo=1, go to RSP.
- RSP: CYC_O=STB_O=0, all bus outputs return to 0. rsp_valid_o=1 for exactly one cycle with captured dat/err/tmo. txn_cnt_o increments, including on errors. Go to HOLD.
- HOLD: POST_IDLE cycles with CYC_O=0, then IDLE. POST_IDLE=0 goes straight to IDLE.
- Latency: command accepted at edge N; earliest STB_O at N+2+gap; response 1 cycle after the terminating edge.
- One outstanding access at a time; no pipelined/burst cycles.
- ACK_I/ERR_I outside BUS are ignored.

Test Plan:
- Reset, then write cmd adr=0, dat=32'h00030201, rnd_en_i=0 -> STB_O rises 2+GAP_MIN=6 cycles after accept. ADR_O=0, DAT_O=32'h00030201, WE_O=1. Slave ACK after 3 cycles -> rsp_valid_o pulse with err=0; txn_cnt_o=1; CYC_O low for 5 cycles.
- Read adr=32'h10, slave returns DAT_I=32'hDEADBEEF with ACK -> rsp_dat_o=32'hDEADBEEF, rsp_err_o=0.
- Slave never responds, TIMEOUT=64 -> STB_O high exactly 64 cycles; rsp_err_o=1, rsp_tmo_o=1, rsp_dat_o=0.
- ACK_I and ERR_I asserted together -> rsp_err_o=1, rsp_tmo_o=0.
- Push 5 commands back-to-back with FIFO_DEPTH=4 -> cmd_ready_o low after the 4th until first pop. All 5 complete in order; txn_cnt_o=5.
- rnd_en_i=1, 1000 writes -> every gap lies in [4,19]; at least 8 distinct gap values. Apply RST_I mid-BUS -> CYC_O=0 next edge, no rsp_valid_o, txn_cnt_o=0.
